record_serializer: RTL and testbench

RECORD_SERIALIZER -- requirements
Module: record_serializer

---
 rtl/beagleg_pkg.sv | 21 ++
 rtl/record_serializer.sv | 113 +++++++++++
 tb/tb_record_serializer.sv | 318 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/beagleg_pkg.sv
// Shared constants and state type for the record serializer.
// The CSUM state exists only when RECORD_SERIALIZER_CHECKSUM_EN is defined.
package beagleg_pkg;

    localparam int DEFAULT_WORD_SIZE    = 8;
    localparam int DEFAULT_RECORD_WORDS = 16;

`ifdef RECORD_SERIALIZER_CHECKSUM_EN
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        CSUM  = 2'd2
    } ser_state_t;
`else
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;
`endif

endpackage

// File: rtl/record_serializer.sv
// Splits a wide record from an upstream FIFO into WORD_SIZE words with a valid/ready handshake.
// Optional trailing XOR checksum word: define RECORD_SERIALIZER_CHECKSUM_EN.
module record_serializer
    import beagleg_pkg::*;
#(
    parameter int WORD_SIZE    = DEFAULT_WORD_SIZE,
    parameter int RECORD_WORDS = DEFAULT_RECORD_WORDS
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              fifo_empty,
    output logic                              fifo_read_en,
    input  logic [WORD_SIZE*RECORD_WORDS-1:0] record_in,
    output logic [WORD_SIZE-1:0]              word_out,
    output logic                              word_valid,
    input  logic                              word_ready,
    output logic                              busy,
    output logic [15:0]                       record_count
);

    localparam int REC_W = WORD_SIZE * RECORD_WORDS;
    localparam int IDX_W = $clog2(RECORD_WORDS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RECORD_WORDS - 1);

    ser_state_t           state_reg, state_next;
    logic [REC_W-1:0]     shift_reg, shift_next;
    logic [IDX_W-1:0]     index_reg, index_next;
    logic [15:0]          count_reg, count_next;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
    logic [WORD_SIZE-1:0] csum_reg, csum_next;
`endif

    logic handshake;
    logic final_word;
    logic load;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            shift_reg <= '0;
            index_reg <= '0;
            count_reg <= '0;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
            csum_reg  <= '0;
`endif
        end else begin
            state_reg <= state_next;
            shift_reg <= shift_next;
            index_reg <= index_next;
            count_reg <= count_next;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
            csum_reg  <= csum_next;
`endif
        end
    end

    always_comb begin
        state_next = state_reg;
        shift_next = shift_reg;
        index_next = index_reg;
        count_next = count_reg;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
        csum_next  = csum_reg;
`endif

        word_valid = (state_reg != IDLE);
        busy       = word_valid;
        handshake  = word_valid && word_ready;
        word_out   = shift_reg[WORD_SIZE-1:0];
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
        if (state_reg == CSUM) begin
            word_out = csum_reg;
        end
        final_word = (state_reg == CSUM);
`else
        final_word = (state_reg == SHIFT) && (index_reg == LAST_IDX);
`endif

        // A new record is taken either from idle or in the same cycle the last word leaves.
        load = !fifo_empty && ((state_reg == IDLE) || (handshake && final_word));

        if (handshake) begin
            if (state_reg == SHIFT) begin
                shift_next = shift_reg >> WORD_SIZE;
                index_next = index_reg + 1'b1;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
                csum_next  = csum_reg ^ shift_reg[WORD_SIZE-1:0];
                if (index_reg == LAST_IDX) begin
                    state_next = CSUM;
                end
`endif
            end
            if (final_word) begin
                state_next = IDLE;
                count_next = count_reg + 16'd1;
            end
        end

        if (load) begin
            state_next = SHIFT;
            shift_next = record_in;
            index_next = '0;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
            csum_next  = '0;
`endif
        end
    end

    // Gated by rst_n so no dequeue can leak out while reset is held.
    assign fifo_read_en = load && rst_n;
    assign record_count = count_reg;

endmodule

// File: tb/tb_record_serializer.sv
// Self-checking bench for record_serializer; honours RECORD_SERIALIZER_CHECKSUM_EN when defined.
module tb_record_serializer;

    localparam int W    = 8;
    localparam int R    = 16;
`ifdef RECORD_SERIALIZER_CHECKSUM_EN
    localparam int CS   = 1;
`else
    localparam int CS   = 0;
`endif
    localparam int WPR  = R + CS;
    localparam int RW   = 2;
    localparam int WPRW = RW + CS;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           rst_n;
    logic           fifo_empty;
    logic           fifo_read_en;
    logic [W*R-1:0] record_in;
    logic [W-1:0]   word_out;
    logic           word_valid;
    logic           word_ready;
    logic           busy;
    logic [15:0]    record_count;

    logic            fifo_empty_w;
    logic            fifo_read_en_w;
    logic [W*RW-1:0] record_in_w;
    logic [W-1:0]    word_out_w;
    logic            word_valid_w;
    logic            word_ready_w;
    logic            busy_w;
    logic [15:0]     record_count_w;

    record_serializer #(.WORD_SIZE(W), .RECORD_WORDS(R)) dut (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_read_en(fifo_read_en),
        .record_in(record_in), .word_out(word_out), .word_valid(word_valid),
        .word_ready(word_ready), .busy(busy), .record_count(record_count)
    );

    record_serializer #(.WORD_SIZE(W), .RECORD_WORDS(RW)) dut_wrap (
        .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty_w), .fifo_read_en(fifo_read_en_w),
        .record_in(record_in_w), .word_out(word_out_w), .word_valid(word_valid_w),
        .word_ready(word_ready_w), .busy(busy_w), .record_count(record_count_w)
    );

    // Upstream FIFO model: pointers only move on an observed dequeue.
    logic [W*R-1:0] fmem [0:63];
    int wr_ptr = 0;
    int rd_ptr = 0;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign record_in  = fmem[rd_ptr % 64];
    always @(posedge clk) if (fifo_read_en) rd_ptr <= rd_ptr + 1;

    logic [W-1:0] exp_q [$];
    int checks = 0;
    int errors = 0;
    int rd_pulses = 0;
    int valid_cycles = 0;
    int exp_count = 0;
    logic [W-1:0] last_word = '0;
    logic [W-1:0] prev_word = '0;
    logic prev_stall = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: a record is its words low-to-high, then (optionally) the XOR of them all.
    task automatic push_record(input logic [W*R-1:0] rec);
        logic [W-1:0] x;
        x = '0;
        fmem[wr_ptr % 64] = rec;
        wr_ptr++;
        for (int i = 0; i < R; i++) begin
            exp_q.push_back(rec[i*W +: W]);
            x ^= rec[i*W +: W];
        end
        if (CS == 1) exp_q.push_back(x);
    endtask

    always @(negedge clk) begin
        logic [W-1:0] e;
        #2;
        if (fifo_read_en) rd_pulses++;
        if (word_valid) valid_cycles++;
        if (prev_stall) begin
            checks++;
            if (!word_valid || word_out !== prev_word) begin
                errors++;
                $display("FAIL hold: got valid=%0b word=%h expected valid=1 word=%h", word_valid, word_out, prev_word);
            end
        end
        if (word_valid && word_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL stream: got word %h expected no word", word_out);
            end else begin
                e = exp_q.pop_front();
                if (word_out !== e) begin
                    errors++;
                    $display("FAIL stream: got %h expected %h", word_out, e);
                end
            end
            $display("word %h accepted, count %0d", word_out, record_count);
            last_word = word_out;
        end
        prev_stall = word_valid && !word_ready;
        prev_word  = word_out;
    end

    task automatic wait_idle(input string name);
        bit done;
        done = 1'b0;
        @(posedge clk);
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            #3;
            if (!busy && fifo_empty) begin
                done = 1'b1;
                break;
            end
        end
        check({name, "_timeout"}, 32'(done), 32'd1);
    endtask

    typedef struct {
        logic [W*R-1:0] rec;
        logic [W-1:0]   exp_last;
        logic [W-1:0]   exp_csum;
    } vec_t;
    vec_t tbl [5];

    initial begin
        bit found;
        int done_w;
        bit seen_ffff;
        bit wrapped;
        logic [W*R-1:0] r;

        tbl[0] = '{128'h0F0E0D0C0B0A09080706050403020100, 8'h0F, 8'h00};
        tbl[1] = '{128'h01010101010101010101010101010101, 8'h01, 8'h00};
        tbl[2] = '{128'h000000000000000000000000000000A5, 8'h00, 8'hA5};
        tbl[3] = '{128'h8000000000000000000000003C000000, 8'h80, 8'hBC};
        tbl[4] = '{128'hFFEEDDCCBBAA99887766554433221100, 8'hFF, 8'h00};

        for (int i = 0; i < 64; i++) fmem[i] = '0;
        rst_n = 1'b0;
        word_ready = 1'b1;
        word_ready_w = 1'b1;
        fifo_empty_w = 1'b1;
        record_in_w = 16'hA55A;

        // Reset state, with a record offered so a leaking dequeue would show.
        repeat (3) @(negedge clk);
        fmem[0] = 128'h1;
        wr_ptr = 1;
        #1;
        check("rst_read_en", 32'(fifo_read_en), 32'd0);
        check("rst_valid", 32'(word_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_count", 32'(record_count), 32'd0);
        check("rst_word", 32'(word_out), 32'd0);
        wr_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;

        foreach (tbl[k]) begin
            @(negedge clk);
            rd_pulses = 0;
            valid_cycles = 0;
            push_record(tbl[k].rec);
            wait_idle("tbl");
            exp_count++;
            $display("record %0d done", k);
            check("tbl_count", 32'(record_count), 32'(exp_count));
            check("tbl_read_pulses", 32'(rd_pulses), 32'd1);
            check("tbl_valid_cycles", 32'(valid_cycles), 32'(WPR));
            check("tbl_last_word", 32'(last_word), 32'((CS == 1) ? tbl[k].exp_csum : tbl[k].exp_last));
        end

        // Two back-to-back records: no gap between them.
        @(negedge clk);
        rd_pulses = 0;
        valid_cycles = 0;
        push_record(tbl[4].rec);
        push_record(tbl[0].rec);
        wait_idle("b2b");
        exp_count += 2;
        check("b2b_valid_cycles", 32'(valid_cycles), 32'(2 * WPR));
        check("b2b_read_pulses", 32'(rd_pulses), 32'd2);
        check("b2b_count", 32'(record_count), 32'(exp_count));

        // Backpressure for 3 cycles at word 5.
        @(negedge clk);
        push_record(tbl[0].rec);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (word_valid && word_out == 8'h05) begin
                word_ready = 1'b0;
                found = 1'b1;
                break;
            end
        end
        check("stall_found", 32'(found), 32'd1);
        for (int j = 0; j < 3; j++) begin
            #3;
            check("stall_hold", {23'd0, word_valid, word_out}, {23'd0, 1'b1, 8'h05});
            @(negedge clk);
        end
        word_ready = 1'b1;
        #3;
        check("stall_release", 32'(word_out), 32'h05);
        @(negedge clk);
        #3;
        check("stall_next", {23'd0, word_valid, word_out}, {23'd0, 1'b1, 8'h06});
        wait_idle("stall");
        exp_count++;
        check("stall_count", 32'(record_count), 32'(exp_count));

        // Random records and random backpressure.
        @(negedge clk);
        for (int n = 0; n < 6; n++) begin
            for (int b = 0; b < R; b++) r[b*W +: W] = W'($urandom);
            push_record(r);
        end
        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            word_ready = ($urandom_range(0, 3) != 0);
            #3;
            if (i > 0 && !busy && fifo_empty) break;
        end
        @(negedge clk);
        word_ready = 1'b1;
        exp_count += 6;
        check("rand_drained", 32'(exp_q.size()), 32'd0);
        check("rand_count", 32'(record_count), 32'(exp_count));

        // Reset in the middle of a record, with another record queued.
        @(negedge clk);
        push_record(tbl[0].rec);
        found = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (word_valid && word_out == 8'h07) begin
                found = 1'b1;
                break;
            end
        end
        check("mid_rst_found", 32'(found), 32'd1);
        fmem[wr_ptr % 64] = tbl[1].rec;
        wr_ptr++;
        #3;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        exp_count = 0;
        check("mid_rst_valid", 32'(word_valid), 32'd0);
        check("mid_rst_count", 32'(record_count), 32'd0);
        check("mid_rst_read_en", 32'(fifo_read_en), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        @(negedge clk);
        wr_ptr = rd_ptr;
        @(negedge clk);
        rst_n = 1'b1;
        rd_pulses = 0;
        repeat (5) @(negedge clk);
        #3;
        check("post_rst_idle", {30'd0, busy, word_valid}, 32'd0);
        check("post_rst_pulses", 32'(rd_pulses), 32'd0);

        @(negedge clk);
        push_record(tbl[2].rec);
        wait_idle("post_rst");
        exp_count++;
        check("post_rst_count", 32'(record_count), 32'(exp_count));

        // record_count wrap on a two-word-record instance fed continuously.
        @(negedge clk);
        fifo_empty_w = 1'b0;
        done_w = 0;
        seen_ffff = 1'b0;
        wrapped = 1'b0;
        for (int c = 0; c < 65536 * WPRW + 200; c++) begin
            @(negedge clk);
            #3;
            if (done_w == 65535 * WPRW && !seen_ffff) begin
                seen_ffff = 1'b1;
                check("wrap_ffff", 32'(record_count_w), 32'h0000FFFF);
            end
            if (done_w == 65536 * WPRW) begin
                wrapped = 1'b1;
                check("wrap_zero", 32'(record_count_w), 32'h00000000);
                break;
            end
            if (word_valid_w && word_ready_w) begin
                check("wrap_word", 32'(word_out_w),
                      32'((done_w % WPRW == 0) ? 8'h5A : (done_w % WPRW == 1) ? 8'hA5 : 8'hFF));
                done_w++;
            end
        end
        fifo_empty_w = 1'b1;
        check("wrap_reached", 32'(wrapped), 32'd1);
        $display("wrap test: %0d words", done_w);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
